// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and fixed-latency access sequencer for a shared memory port.
// Bounded bursts; each transfer takes WAIT_CYC access cycles plus one ack cycle.
module mem_arbiter #(
  parameter int unsigned AW        = 13,
  parameter int unsigned DW        = 8,
  parameter int unsigned WAIT_CYC  = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rd0,
  input  logic          rd1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e        state_q, state_d;
  logic          gnt0_q, gnt1_q;
  logic          last_q;
  logic [BW-1:0] burst_q;
  logic [WW-1:0] wait_q;
  logic [DW-1:0] rdata_q;

  logic          any_req;
  logic          keep_last;
  logic          win1;
  logic          sel_rd, sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          last_access;

  assign any_req     = req0 | req1;
  assign last_access = (state_q == StAccess) && (wait_q == '0);

  // burst_q == 0 only after reset: nobody has been served yet, so the pointer (reset to
  // master 1) is passed over and master 0 takes the first simultaneous request.
  assign keep_last = (burst_q != '0) && (burst_q < BW'(MAX_BURST));

  always_comb begin
    win1 = req1;
    if (req0 && req1) begin
      win1 = keep_last ? last_q : ~last_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: if (wait_q == '0) state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Grant, arbitration history, wait counter and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt0_q <= ~win1;
            gnt1_q <= win1;
            wait_q <= WW'(WAIT_CYC - 1);
            last_q <= win1;
            if (win1 == last_q) begin
              if (burst_q != BW'(MAX_BURST)) burst_q <= burst_q + BW'(1);
            end else begin
              burst_q <= BW'(1);
            end
          end
        end
        StAccess: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WW'(1);
          end else if (sel_rd && !sel_wr) begin
            rdata_q <= mem_rdata;
          end
        end
        StAck: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1_q) begin
      sel_rd    = rd1;
      sel_wr    = wr1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else if (gnt0_q) begin
      sel_rd    = rd0;
      sel_wr    = wr0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = (state_q == StAck) && gnt0_q;
  assign ack1      = (state_q == StAck) && gnt1_q;
  assign busy      = (state_q != StIdle);
  assign mem_wr    = (state_q == StAccess) && sel_wr;
  assign mem_rd    = (state_q == StAccess) && sel_rd && !sel_wr;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign rdata     = rdata_q;

  logic unused_last_access;
  assign unused_last_access = last_access;

endmodule
